// File: rtl/encoder4_2_pending.sv
// Sequential 4-to-2 encoder with sticky request capture and ack handshake.
// Define ENC_ROUND_ROBIN_EN for rotating priority; otherwise priority is fixed (3 highest).
module encoder4_2_pending #(
    parameter logic [1:0] IDLE_CODE = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] Y,
    output logic       valid,
    output logic [3:0] pending,
    output logic       multi
);

    logic       take;
    logic [3:0] clr;
    logic [3:0] pnext;
    logic [1:0] ptr_sel;
    logic [1:0] idx;
    logic [1:0] sel_code;
    logic       sel_found;
    logic       multi_next;

    assign take = valid & ack;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clr   = take ? (4'b0001 << Y) : 4'b0000;
        pnext = (pending & ~clr) | req;
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 2'd3;
        else if (take)
            ptr <= Y - 2'd1;
    end

    // The search on an ack edge already uses the rotated pointer, so the served line drops to last place at once.
    assign ptr_sel = take ? (Y - 2'd1) : ptr;
`else
    assign ptr_sel = 2'd3;
`endif

    always_comb begin
        sel_code  = IDLE_CODE;
        sel_found = 1'b0;
        idx       = ptr_sel;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_sel - 2'(i);
            if (!sel_found && pnext[idx]) begin
                sel_code  = idx;
                sel_found = 1'b1;
            end
        end
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something behind.
    assign multi_next = |(pnext & (pnext - 4'd1));

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'b0000;
            Y       <= IDLE_CODE;
            valid   <= 1'b0;
            multi   <= 1'b0;
        end else begin
            pending <= pnext;
            Y       <= sel_code;
            valid   <= |pnext;
            multi   <= multi_next;
        end
    end

endmodule

// File: tb/tb_encoder4_2_pending.sv
// Self-checking bench for encoder4_2_pending: directed literal cases plus random traffic vs a behavioural model.
// Honours ENC_ROUND_ROBIN_EN the same way as the design.
module tb_encoder4_2_pending;

    localparam logic [1:0] IDLE = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [1:0] Y;
    logic       valid;
    logic [3:0] pending;
    logic       multi;

    int n_checks = 0;
    int n_errors = 0;

    encoder4_2_pending #(.IDLE_CODE(IDLE)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .Y(Y), .valid(valid), .pending(pending), .multi(multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a set of pending lines and a "most favoured line" index.
    logic [3:0] m_pend;
    logic [1:0] m_y;
    logic       m_valid;
    logic       m_multi;
    int         m_ptr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  = 4'b0000;
            m_y     = IDLE;
            m_valid = 1'b0;
            m_multi = 1'b0;
            m_ptr   = 3;
        end else begin
            logic [3:0] np;
            bit served;
            served = m_valid && ack;
            np = m_pend;
            if (served) np[m_y] = 1'b0;
            np = np | req;
`ifdef ENC_ROUND_ROBIN_EN
            if (served) m_ptr = (int'(m_y) + 3) % 4;
`endif
            m_y = IDLE;
            for (int k = 3; k >= 0; k--) begin
                int line;
                line = (m_ptr - k + 4) % 4;
                if (np[line]) m_y = 2'(line);
            end
            m_pend  = np;
            m_valid = (np != 0);
            m_multi = ($countones(np) >= 2);
        end
    end

    // Compare process: outputs are registered, so checking on every falling edge covers every cycle.
    always @(negedge clk) begin
        check("model", {24'd0, Y, valid, pending, multi},
              {24'd0, m_y, m_valid, m_pend, m_multi});
    end

    task automatic drive(input logic [3:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [1:0] ey, input logic ev,
                              input logic [3:0] ep, input logic em);
        check(name, {24'd0, Y, valid, pending, multi}, {24'd0, ey, ev, ep, em});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    logic [1:0] rr_exp [6];

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle with all requests asserted
        drive(4'b0110, 1'b0);
        expect_out("pre_reset", 2'd2, 1'b1, 4'b0110, 1'b1);
        #2;
        req = 4'b1111;
        rst = 1'b1;
        #1;
        expect_out("reset_async", IDLE, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("reset_release", 2'd3, 1'b1, 4'b1111, 1'b1);

        // Single request held until acked
        do_reset();
        drive(4'b0100, 1'b0);
        expect_out("single_cap", 2'd2, 1'b1, 4'b0100, 1'b0);
        drive(4'b0000, 1'b0);
        drive(4'b0000, 1'b0);
        expect_out("single_hold", 2'd2, 1'b1, 4'b0100, 1'b0);
        drive(4'b0000, 1'b1);
        expect_out("single_ack", IDLE, 1'b0, 4'b0000, 1'b0);
        drive(4'b0000, 1'b1);
        expect_out("ack_when_idle", IDLE, 1'b0, 4'b0000, 1'b0);

        // Drain of 1011
        do_reset();
        drive(4'b1011, 1'b0);
        expect_out("drain_0", 2'd3, 1'b1, 4'b1011, 1'b1);
        drive(4'b0000, 1'b1);
        expect_out("drain_1", 2'd1, 1'b1, 4'b0011, 1'b1);
        drive(4'b0000, 1'b1);
        expect_out("drain_2", 2'd0, 1'b1, 4'b0001, 1'b0);
        drive(4'b0000, 1'b1);
        expect_out("drain_3", IDLE, 1'b0, 4'b0000, 1'b0);

        // Set wins over clear
        do_reset();
        drive(4'b0010, 1'b0);
        drive(4'b0010, 1'b1);
        expect_out("set_wins", 2'd1, 1'b1, 4'b0010, 1'b0);

        // Preemption by a higher line
        do_reset();
        drive(4'b0001, 1'b0);
        expect_out("preempt_0", 2'd0, 1'b1, 4'b0001, 1'b0);
        drive(4'b1000, 1'b0);
        expect_out("preempt_1", 2'd3, 1'b1, 4'b1001, 1'b1);
        drive(4'b0000, 1'b1);
        expect_out("preempt_ack", 2'd0, 1'b1, 4'b0001, 1'b0);

        // All lines held with ack every cycle
        do_reset();
`ifdef ENC_ROUND_ROBIN_EN
        rr_exp = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
`else
        rr_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        drive(4'b1111, 1'b0);
        expect_out("rr_first", 2'd3, 1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 1'b1);
            expect_out($sformatf("rr_%0d", i), rr_exp[i], 1'b1, 4'b1111, 1'b1);
        end

        // Random traffic, checked by the compare process every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            drive(r, 1'($urandom_range(0, 2) != 0));
            if (i == 1500) do_reset();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
